// File: rtl/user_proj_timer_mc_if.sv
// -----------------------------------------------------------------------------
// user_proj_timer_mc_if
//   Wishbone classic slave bus for the multi-channel timer. Signal names keep
//   the Caravel user-project wbs_* names so board-level wiring reads the same.
//
//   wbs_stb_i  strobe                 wbs_cyc_i  cycle
//   wbs_we_i   write enable           wbs_sel_i  byte select (unused by slave)
//   wbs_adr_i  byte address [31:0]    wbs_dat_i  write data [31:0]
//   wbs_ack_o  acknowledge            wbs_dat_o  read data [31:0]
//
//   master: drives request side (CPU / testbench)
//   slave : drives ack and read data (timer)
// -----------------------------------------------------------------------------
`timescale 1ns / 1ps

interface user_proj_timer_mc_if;
    logic        wbs_stb_i;
    logic        wbs_cyc_i;
    logic        wbs_we_i;
    logic [3:0]  wbs_sel_i;
    logic [31:0] wbs_adr_i;
    logic [31:0] wbs_dat_i;
    logic        wbs_ack_o;
    logic [31:0] wbs_dat_o;

    modport master (
        output wbs_stb_i, wbs_cyc_i, wbs_we_i, wbs_sel_i, wbs_adr_i, wbs_dat_i,
        input  wbs_ack_o, wbs_dat_o
    );

    modport slave (
        input  wbs_stb_i, wbs_cyc_i, wbs_we_i, wbs_sel_i, wbs_adr_i, wbs_dat_i,
        output wbs_ack_o, wbs_dat_o
    );
endinterface

// File: rtl/user_proj_timer_mc.sv
// -----------------------------------------------------------------------------
// user_proj_timer_mc
//   NCH independent WIDTH-bit timer channels (one-shot, periodic square wave or
//   PWM) sharing one PRE_W-bit prescaler, configured over Wishbone.
//
//   wb_clk_i   system clock
//   wb_rst_i   asynchronous active-low reset
//   wbs        Wishbone slave (user_proj_timer_mc_if.slave)
//   io_out     one output per channel
//   io_oeb     pad output enables, tied to 0 (always driving)
//   user_irq   OR over channels of (IRQ_STAT & IRQ_EN)
//
//   Map: channel c at c*0x10: +0 CTRL {MODE[2:1],EN[0]}, +4 LOAD, +8 CMP,
//        +C COUNT (ro). Global: 0x100 PRESCALE, 0x104 IRQ_STAT (W1C),
//        0x108 IRQ_EN. Only address bits [8:2] are decoded.
// -----------------------------------------------------------------------------
`timescale 1ns / 1ps

module user_proj_timer_mc #(
    parameter int NCH   = 4,
    parameter int WIDTH = 16,
    parameter int PRE_W = 16
) (
    input  logic                 wb_clk_i,
    input  logic                 wb_rst_i,
    user_proj_timer_mc_if.slave  wbs,
    output logic [NCH-1:0]       io_out,
    output logic [NCH-1:0]       io_oeb,
    output logic                 user_irq
);

    typedef enum logic [1:0] {
        MODE_ONESHOT  = 2'b00,
        MODE_PERIODIC = 2'b01,
        MODE_PWM      = 2'b10,
        MODE_RSVD     = 2'b11
    } mode_e;

    typedef enum logic [1:0] {
        REG_CTRL  = 2'd0,
        REG_LOAD  = 2'd1,
        REG_CMP   = 2'd2,
        REG_COUNT = 2'd3
    } ch_reg_e;

    localparam logic [5:0] G_PRESCALE = 6'd0;
    localparam logic [5:0] G_IRQ_STAT = 6'd1;
    localparam logic [5:0] G_IRQ_EN   = 6'd2;

    // ------------------------------------------------------------------
    // Bus front end
    // ------------------------------------------------------------------
    logic        ack_q;
    logic [31:0] dat_q;
    logic [31:0] rdata;
    logic        req;
    logic        wr;
    logic        wr_ch;
    logic        wr_glob;
    logic        is_glob;
    logic [3:0]  ch_idx;
    ch_reg_e     reg_idx;
    logic [5:0]  glob_idx;

    // A request is taken only while ack is low, giving one access per two cycles.
    assign req      = wbs.wbs_stb_i & wbs.wbs_cyc_i & ~ack_q;
    assign wr       = req & wbs.wbs_we_i;
    assign is_glob  = wbs.wbs_adr_i[8];
    assign ch_idx   = wbs.wbs_adr_i[7:4];
    assign reg_idx  = ch_reg_e'(wbs.wbs_adr_i[3:2]);
    assign glob_idx = wbs.wbs_adr_i[7:2];
    assign wr_ch    = wr & ~is_glob;
    assign wr_glob  = wr &  is_glob;

    // Byte selects and undecoded address bits have no effect.
    logic unused_bits;
    assign unused_bits = ^{wbs.wbs_sel_i, wbs.wbs_adr_i[31:9], wbs.wbs_adr_i[1:0],
                           wbs.wbs_dat_i};

    // ------------------------------------------------------------------
    // Prescaler and global registers
    // ------------------------------------------------------------------
    logic [PRE_W-1:0] prescale_q, prescale_d;
    logic [PRE_W-1:0] pre_cnt_q,  pre_cnt_d;
    logic [NCH-1:0]   irq_stat_q, irq_stat_d;
    logic [NCH-1:0]   irq_en_q,   irq_en_d;
    logic [NCH-1:0]   evt_vec;
    logic             tick;

    assign tick = (pre_cnt_q == prescale_q);

    always_comb begin
        // NOTE: every always_comb output gets a default first so no path can
        // leave it unassigned and infer a latch.
        prescale_d = prescale_q;
        pre_cnt_d  = tick ? '0 : pre_cnt_q + PRE_W'(1);
        irq_stat_d = irq_stat_q;
        irq_en_d   = irq_en_q;

        if (wr_glob) begin
            case (glob_idx)
                G_PRESCALE: begin
                    prescale_d = wbs.wbs_dat_i[PRE_W-1:0];
                    pre_cnt_d  = '0;
                end
                G_IRQ_STAT: irq_stat_d = irq_stat_q & ~wbs.wbs_dat_i[NCH-1:0];
                G_IRQ_EN:   irq_en_d   = wbs.wbs_dat_i[NCH-1:0];
                default: ;
            endcase
        end

        // Applied after the W1C so a same-cycle event keeps its bit set.
        irq_stat_d = irq_stat_d | evt_vec;
    end

    always_ff @(posedge wb_clk_i or negedge wb_rst_i) begin
        if (!wb_rst_i) begin
            prescale_q <= '0;
            pre_cnt_q  <= '0;
            irq_stat_q <= '0;
            irq_en_q   <= '0;
        end else begin
            // NOTE: state registers use non-blocking assignments so every
            // flop samples the pre-edge value of every other flop.
            prescale_q <= prescale_d;
            pre_cnt_q  <= pre_cnt_d;
            irq_stat_q <= irq_stat_d;
            irq_en_q   <= irq_en_d;
        end
    end

    // ------------------------------------------------------------------
    // Channels
    // ------------------------------------------------------------------
    logic [NCH-1:0][2:0]       ctrl_vec;
    logic [NCH-1:0][WIDTH-1:0] load_vec;
    logic [NCH-1:0][WIDTH-1:0] cmp_vec;
    logic [NCH-1:0][WIDTH-1:0] count_vec;
    logic [NCH-1:0]            out_vec;

    for (genvar c = 0; c < NCH; c++) begin : g_ch
        logic             en_q,    en_d;
        mode_e            mode_q,  mode_d;
        logic [WIDTH-1:0] load_q,  load_d;
        logic [WIDTH-1:0] cmp_q,   cmp_d;
        logic [WIDTH-1:0] count_q, count_d;
        logic             tog_q,   tog_d;
        logic             sel;
        logic             match;
        logic             out;

        assign sel   = wr_ch && (ch_idx == 4'(c));
        // >= rather than == so lowering LOAD below COUNT wraps on the next tick.
        assign match = (count_q >= load_q);
        assign evt_vec[c] = tick && en_q && match;

        always_comb begin
            en_d    = en_q;
            mode_d  = mode_q;
            load_d  = load_q;
            cmp_d   = cmp_q;
            count_d = count_q;
            tog_d   = tog_q;

            if (tick && en_q) begin
                if (match) begin
                    count_d = '0;
                    tog_d   = ~tog_q;
                    if (mode_q == MODE_ONESHOT) begin
                        en_d = 1'b0;
                    end
                end else begin
                    count_d = count_q + WIDTH'(1);
                end
            end

            // Software writes are layered over the counter update, so they
            // take effect after a same-cycle event and override auto-clear.
            if (sel) begin
                case (reg_idx)
                    REG_CTRL: begin
                        en_d   = wbs.wbs_dat_i[0];
                        mode_d = mode_e'(wbs.wbs_dat_i[2:1]);
                        if (wbs.wbs_dat_i[0] && !en_q) begin
                            count_d = '0;
                            tog_d   = 1'b0;
                        end
                    end
                    REG_LOAD: load_d = wbs.wbs_dat_i[WIDTH-1:0];
                    REG_CMP:  cmp_d  = wbs.wbs_dat_i[WIDTH-1:0];
                    default: ;  // COUNT is read-only
                endcase
            end
        end

        always_ff @(posedge wb_clk_i or negedge wb_rst_i) begin
            if (!wb_rst_i) begin
                en_q    <= 1'b0;
                mode_q  <= MODE_ONESHOT;
                load_q  <= '0;
                cmp_q   <= '0;
                count_q <= '0;
                tog_q   <= 1'b0;
            end else begin
                en_q    <= en_d;
                mode_q  <= mode_d;
                load_q  <= load_d;
                cmp_q   <= cmp_d;
                count_q <= count_d;
                tog_q   <= tog_d;
            end
        end

        always_comb begin
            out = 1'b0;
            if (en_q) begin
                case (mode_q)
                    MODE_ONESHOT: out = 1'b1;
                    MODE_PWM:     out = (count_q < cmp_q);
                    default:      out = tog_q;  // periodic and reserved
                endcase
            end
        end

        assign ctrl_vec[c]  = {mode_q, en_q};
        assign load_vec[c]  = load_q;
        assign cmp_vec[c]   = cmp_q;
        assign count_vec[c] = count_q;
        assign out_vec[c]   = out;
    end

    // ------------------------------------------------------------------
    // Read mux; unpopulated channels and unmapped globals read 0
    // ------------------------------------------------------------------
    always_comb begin
        rdata = '0;
        if (is_glob) begin
            case (glob_idx)
                G_PRESCALE: rdata = 32'(prescale_q);
                G_IRQ_STAT: rdata = 32'(irq_stat_q);
                G_IRQ_EN:   rdata = 32'(irq_en_q);
                default: ;
            endcase
        end else begin
            for (int c = 0; c < NCH; c++) begin
                if (ch_idx == 4'(c)) begin
                    case (reg_idx)
                        REG_CTRL:  rdata = 32'(ctrl_vec[c]);
                        REG_LOAD:  rdata = 32'(load_vec[c]);
                        REG_CMP:   rdata = 32'(cmp_vec[c]);
                        default:   rdata = 32'(count_vec[c]);
                    endcase
                end
            end
        end
    end

    always_ff @(posedge wb_clk_i or negedge wb_rst_i) begin
        if (!wb_rst_i) begin
            ack_q <= 1'b0;
            dat_q <= '0;
        end else begin
            ack_q <= req;
            dat_q <= (req && !wbs.wbs_we_i) ? rdata : '0;
        end
    end

    assign wbs.wbs_ack_o = ack_q;
    assign wbs.wbs_dat_o = dat_q;
    assign io_out        = out_vec;
    assign io_oeb        = '0;
    assign user_irq      = |(irq_stat_q & irq_en_q);

endmodule

// File: tb/tb_user_proj_timer_mc.sv
`timescale 1ns / 1ps

module tb_user_proj_timer_mc;

    localparam int NCH = 4;

    logic           clk = 1'b0;
    logic           rst_n = 1'b0;
    logic [NCH-1:0] io_out;
    logic [NCH-1:0] io_oeb;
    logic           user_irq;

    int n_checks = 0;
    int n_fail   = 0;

    user_proj_timer_mc_if bus ();

    user_proj_timer_mc #(
        .NCH   (NCH),
        .WIDTH (16),
        .PRE_W (16)
    ) dut (
        .wb_clk_i (clk),
        .wb_rst_i (rst_n),
        .wbs      (bus),
        .io_out   (io_out),
        .io_oeb   (io_oeb),
        .user_irq (user_irq)
    );

    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time exceeded");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Drives from just after an edge; returns 1 ns after the edge where ack is seen.
    task automatic wb_xfer(input logic we, input logic [31:0] adr, input logic [31:0] wdat,
                           output logic [31:0] rdat);
        int n;
        bus.wbs_stb_i = 1'b1;
        bus.wbs_cyc_i = 1'b1;
        bus.wbs_we_i  = we;
        bus.wbs_sel_i = 4'hF;
        bus.wbs_adr_i = adr;
        bus.wbs_dat_i = wdat;
        n = 0;
        do begin
            @(posedge clk);
            #1;
            n++;
        end while (!bus.wbs_ack_o && n < 4);
        if (!bus.wbs_ack_o) check("ack_timeout", {31'b0, bus.wbs_ack_o}, 32'd1);
        rdat = bus.wbs_dat_o;
        bus.wbs_stb_i = 1'b0;
        bus.wbs_cyc_i = 1'b0;
        bus.wbs_we_i  = 1'b0;
    endtask

    task automatic wb_write(input logic [31:0] adr, input logic [31:0] wdat);
        logic [31:0] dummy;
        wb_xfer(1'b1, adr, wdat, dummy);
    endtask

    task automatic wb_read(input logic [31:0] adr, output logic [31:0] rdat);
        wb_xfer(1'b0, adr, 32'd0, rdat);
    endtask

    initial begin
        logic [31:0] rd;
        int          k;
        int          hi;

        bus.wbs_stb_i = 1'b0;
        bus.wbs_cyc_i = 1'b0;
        bus.wbs_we_i  = 1'b0;
        bus.wbs_sel_i = 4'h0;
        bus.wbs_adr_i = '0;
        bus.wbs_dat_i = '0;

        // ---- reset state ----
        repeat (2) @(posedge clk);
        #1;
        check("rst_io_out",  32'(io_out), 32'h0);
        check("rst_io_oeb",  32'(io_oeb), 32'h0);
        check("rst_irq",     32'(user_irq), 32'h0);
        check("rst_ack",     32'(bus.wbs_ack_o), 32'h0);
        check("rst_dat",     bus.wbs_dat_o, 32'h0);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // ---- periodic ch0: LOAD=3, toggles every 4 cycles ----
        wb_write(32'h004, 32'd3);
        wb_read(32'h004, rd);
        check("ch0_load_rb", rd, 32'd3);
        wb_write(32'h000, 32'b011);
        check("per_k0", 32'(io_out[0]), 32'd0);
        for (int i = 1; i <= 12; i++) begin
            @(posedge clk);
            #1;
            check($sformatf("per_k%0d", i), 32'(io_out[0]), 32'((i / 4) % 2));
        end
        wb_read(32'h104, rd);
        check("per_irq_stat", rd, 32'h1);
        @(posedge clk);
        #1;
        check("ack_drops", 32'(bus.wbs_ack_o), 32'd0);
        wb_write(32'h000, 32'd0);
        wb_write(32'h104, 32'hF);
        wb_read(32'h104, rd);
        check("stat_cleared", rd, 32'h0);

        // ---- PWM ch1: LOAD=9, CMP=3 -> 3 high / 7 low ----
        wb_write(32'h014, 32'd9);
        wb_write(32'h018, 32'd3);
        wb_write(32'h010, 32'b101);
        check("pwm_k0", 32'(io_out[1]), 32'd1);
        for (int i = 1; i <= 20; i++) begin
            @(posedge clk);
            #1;
            check($sformatf("pwm_k%0d", i), 32'(io_out[1]), 32'((i % 10) < 3));
        end
        wb_write(32'h018, 32'd0);
        hi = 0;
        for (int i = 0; i < 10; i++) begin
            if (io_out[1]) hi++;
            @(posedge clk);
            #1;
        end
        check("pwm_cmp0_hi", 32'(hi), 32'd0);
        wb_write(32'h018, 32'd12);
        hi = 0;
        for (int i = 0; i < 10; i++) begin
            if (io_out[1]) hi++;
            @(posedge clk);
            #1;
        end
        check("pwm_cmp12_hi", 32'(hi), 32'd10);
        wb_write(32'h010, 32'd0);

        // ---- one-shot ch2: PRESCALE=4, LOAD=2 -> 15 cycles ----
        wb_write(32'h024, 32'd2);
        wb_write(32'h100, 32'd4);
        repeat (4) @(posedge clk);
        #1;
        wb_write(32'h020, 32'b001);  // lands on a tick edge: prescaler restarts at 0
        check("os_start", 32'(io_out[2]), 32'd1);
        k = 0;
        while (io_out[2] && k < 40) begin
            @(posedge clk);
            #1;
            k++;
        end
        check("os_latency", 32'(k), 32'd15);
        check("os_out_low", 32'(io_out[2]), 32'd0);
        wb_read(32'h020, rd);
        check("os_ctrl", rd, 32'h0);
        wb_read(32'h02C, rd);
        check("os_count", rd, 32'h0);

        // ---- interrupts ----
        wb_write(32'h108, 32'h4);
        check("irq_en_on", 32'(user_irq), 32'd1);
        wb_write(32'h104, 32'hF);
        check("irq_clr", 32'(user_irq), 32'd0);
        wb_write(32'h100, 32'd0);
        wb_write(32'h024, 32'd3);
        wb_write(32'h020, 32'b011);
        repeat (3) @(posedge clk);
        #1;
        check("irq_pre_evt", 32'(user_irq), 32'd0);
        wb_write(32'h104, 32'h4);  // lands on the same edge as the first event
        check("irq_evt_wins", 32'(user_irq), 32'd1);
        wb_read(32'h104, rd);
        check("irq_stat_rd", rd, 32'h4);
        wb_write(32'h020, 32'd0);
        wb_write(32'h104, 32'h4);
        check("irq_clr2", 32'(user_irq), 32'd0);

        // ---- LOAD lowered below COUNT ----
        wb_write(32'h004, 32'd200);
        wb_write(32'h000, 32'b011);
        repeat (99) @(posedge clk);
        #1;
        wb_write(32'h004, 32'd5);  // lands as COUNT becomes 100
        check("lowload_pre", 32'(io_out[0]), 32'd0);
        @(posedge clk);
        #1;
        check("lowload_evt", 32'(io_out[0]), 32'd1);
        wb_read(32'h00C, rd);
        check("lowload_cnt", rd, 32'd0);
        wb_write(32'h000, 32'd0);

        // ---- unmapped reads ----
        wb_read(32'h0F0, rd);
        check("unpop_ch", rd, 32'h0);
        wb_read(32'h10C, rd);
        check("unmap_glob", rd, 32'h0);

        // ---- full-scale wrap on ch3 ----
        wb_write(32'h108, 32'h8);
        wb_write(32'h034, 32'hFFFF);
        wb_write(32'h030, 32'b011);
        repeat (65535) @(posedge clk);
        #1;
        check("wrap_pre_out", 32'(io_out[3]), 32'd0);
        check("wrap_pre_irq", 32'(user_irq), 32'd0);
        @(posedge clk);
        #1;
        check("wrap_out", 32'(io_out[3]), 32'd1);
        check("wrap_irq", 32'(user_irq), 32'd1);
        wb_read(32'h03C, rd);
        check("wrap_count", rd, 32'h0);

        // ---- asynchronous reset mid-count ----
        check("mid_out_hi", 32'(io_out[3]), 32'd1);
        rst_n = 1'b0;
        #1;
        check("mid_rst_out", 32'(io_out), 32'h0);
        check("mid_rst_irq", 32'(user_irq), 32'h0);
        check("mid_rst_ack", 32'(bus.wbs_ack_o), 32'h0);
        check("mid_rst_dat", bus.wbs_dat_o, 32'h0);
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        wb_read(32'h03C, rd);
        check("mid_rst_count", rd, 32'h0);
        wb_read(32'h030, rd);
        check("mid_rst_ctrl", rd, 32'h0);
        wb_read(32'h104, rd);
        check("mid_rst_stat", rd, 32'h0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/user_proj_timer_mc.md
Name: user_proj_timer_mc

Overview:
Parametrised multi-channel timer/PWM, successor to the single-channel user timer in the user project area. It provides NCH independent channels, each WIDTH bits wide and each selectable as one-shot, periodic (square wave) or PWM. All channels share one programmable prescaler. Configuration is through a Wishbone slave. Each channel drives one pad output, and a masked, combined interrupt goes to user_irq.

Parameters:
NCH, 4, number of channels (1..16)
WIDTH, 16, counter/LOAD/CMP width (8..32)
PRE_W, 16, prescaler width (1..32)

Ports:
wb_clk_i  input  1  system clock, single clock domain
wb_rst_i  input  1  reset, asynchronous assert, active-low
wbs_stb_i  input  1  Wishbone strobe
wbs_cyc_i  input  1  Wishbone cycle
wbs_we_i  input  1  write enable
wbs_sel_i  input  4  byte select; ignored, all writes are full-word
wbs_adr_i  input  32  byte address; only bits [8:2] are decoded
wbs_dat_i  input  32  write data
wbs_ack_o  output  1  acknowledge
wbs_dat_o  output  32  read data
io_out  output  NCH  channel outputs
io_oeb  output  NCH  pad output enables; constant 0 (always driving)
user_irq  output  1  OR over channels of (IRQ_STAT & IRQ_EN)

Behaviour:
- Reset (wb_rst_i=0, asynchronous):
  - all registers, counters, prescaler, toggle flops and ack are cleared to 0;
  - outputs after reset: io_out=0, wbs_ack_o=0, wbs_dat_o=0, user_irq=0.
- Register map (byte address):
  - Channel c, base c*0x10: +0x0 CTRL (bit0 EN; bits[2:1] MODE: 00 one-shot, 01 periodic, 10 PWM, 11 reserved and behaves as periodic), +0x4 LOAD, +0x8 CMP, +0xC COUNT (read-only).
  - Global: 0x100 PRESCALE, 0x104 IRQ_STAT (write-1-to-clear), 0x108 IRQ_EN.
  - Unused upper bits read as 0. Unmapped or unpopulated-channel reads return 0; writes there are ignored.
- Wishbone handshake:
  - stb&cyc&!ack -> ack=1 on the next cycle, with wbs_dat_o valid in that same cycle; ack returns to 0 the cycle after.
  - One access per two cycles; no wait states beyond that; no error responses.
- Prescaler:
  - free-running pre_cnt; tick=1 for one cycle when pre_cnt==PRESCALE, and pre_cnt then returns to 0;
  - PRESCALE=0 -> tick every cycle;
  - a PRESCALE write resets pre_cnt to 0.
- Channel counter (advances only on tick while EN=1):
  - match = (COUNT >= LOAD); using >= means a LOAD lowered below COUNT matches on the next tick.
  - On tick: if match, COUNT<=0 and an event is raised; otherwise COUNT<=COUNT+1. Period is therefore LOAD+1 ticks.
  - A CTRL write taking EN from 0 to 1 clears COUNT, the toggle flop and pre-state of the output. Writing EN=0 freezes COUNT.
- Modes:
  - one-shot: io_out=1 while EN=1; on the event EN is cleared by hardware, COUNT=0, io_out=0.
  - periodic: a toggle flop inverts on each event; io_out=toggle.
  - PWM: io_out = (COUNT < CMP). CMP=0 -> constant 0; CMP>LOAD -> constant 1. The event fires at wrap.
  - EN=0 in any mode -> io_out=0.
- Interrupts:
  - an event sets IRQ_STAT[c];
  - if a W1C clear and a new event land on the same bit in the same cycle, the event wins and the bit stays 1;
  - user_irq is combinational from the registers.
- Register writes during the cycle of an event take effect after that event. If software writes CTRL in the same cycle as the one-shot auto-clear, the software write wins.
- Reset mid-operation aborts everything immediately; there is no pending-state retention.

Test Plan:
1. Reset check: hold wb_rst_i=0 mid-count -> io_out=0, COUNT reads 0, user_irq=0, ack=0.
2. Periodic ch0: PRESCALE=0, LOAD=3, CTRL=0b011 -> io_out[0] toggles every 4 cycles; IRQ_STAT[0]=1 after the first event.
3. PWM ch1: LOAD=9, CMP=3 -> 3 high / 7 low per 10 ticks. CMP=0 -> constant 0; CMP=12 -> constant 1.
4. One-shot ch2: PRESCALE=4, LOAD=2, CTRL=0b001 -> event after 15 cycles; CTRL reads 0 afterwards; io_out[2] falls.
5. IRQ: IRQ_EN=0x4 with the ch2 event -> user_irq=1. Write IRQ_STAT=0x4 in the same cycle as a fresh event -> bit stays 1. Clear with no event -> user_irq=0.
6. Boundary: LOAD=0xFFFF with COUNT=0xFFFF -> wraps to 0 with an event. Write LOAD=5 while COUNT=100 -> event on the next tick. Read 0x0F0 with NCH=4 -> returns 0.
